shift_cmd_issuer: RTL and testbench

Upstream command stage for the 8-bit left-shifter array. Accepts shift requests (operand plus 4-bit amount) over a valid/ready interface and buffers them in a small FIFO. It drives the shifter's `a`/`s2`/`s1`/`s0` inputs one pass per cycle, capturing the shifter's combinational output `o`. Amounts 8–15 are executed as two chained passes, and each registered result is presented downstream with its own valid/ready handshake.

---
 rtl/shift_cmd_issuer.sv | 97 +++++++++
 tb/tb_shift_cmd_issuer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_issuer.sv
// shift_cmd_issuer: FIFO-buffered command issuer driving an 8-bit shifter, two chained passes for amounts 8..15; define SHIFT_OVF_EN to add out_ovf
module shift_cmd_issuer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic [3:0]                   in_amt,
  output logic [7:0]                   sh_a,
  output logic                         sh_s2,
  output logic                         sh_s1,
  output logic                         sh_s0,
  input  logic [7:0]                   sh_o,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]  level
`ifdef SHIFT_OVF_EN
  ,
  output logic                         out_ovf
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, PASS1, PASS2, HOLD} state_t;
  state_t state, nxt;
  logic [11:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [11:0] head;
  logic [7:0] work;
  logic [2:0] p2_sel, sel;
  logic push, pop;
  assign head = mem[rptr];
  assign push = in_valid & in_ready;
  assign pop = state == PASS1;
  assign in_ready = level != FULL;
  assign out_valid = state == HOLD;
  assign out_data = work;
  assign {sh_s2, sh_s1, sh_s0} = sel;
  // Command storage; entries beyond level are don't-care so no reset needed
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {in_amt, in_data};
  // FIFO pointers and occupancy; push and pop together leave level unchanged
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  // State, work/result register and the second-pass select (amt-7, clamped to 7 for amt 15)
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      p2_sel <= '0;
    end else begin
      state <= nxt;
      if (state == PASS1 || state == PASS2) work <= sh_o;
      if (state == PASS1) p2_sel <= &head[10:8] ? 3'd7 : head[10:8] + 3'd1;
    end
  // Next state and shifter drive; shifter inputs are zero outside the pass states
  always_comb begin
    nxt = state;
    sh_a = '0;
    sel = '0;
    case (state)
      IDLE: nxt = level != '0 ? PASS1 : IDLE;
      PASS1: begin
        sh_a = head[7:0];
        sel = head[11] ? 3'd7 : head[10:8];
        nxt = head[11] ? PASS2 : HOLD;
      end
      PASS2: begin
        sh_a = work;
        sel = p2_sel;
        nxt = HOLD;
      end
      default: nxt = out_ready ? (level != '0 ? PASS1 : IDLE) : HOLD;
    endcase
  end
`ifdef SHIFT_OVF_EN
  logic ovf_q, ovf_pass;
  assign ovf_pass = |(sh_a & ~(8'hff >> sel));
  assign out_ovf = ovf_q;
  // Overflow flag: restarts on PASS1, accumulates across PASS2
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (state == PASS1) ovf_q <= ovf_pass;
    else if (state == PASS2) ovf_q <= ovf_q | ovf_pass;
`endif
endmodule

// File: tb/tb_shift_cmd_issuer.sv
// tb_shift_cmd_issuer: directed scoreboard bench for shift_cmd_issuer with a behavioural shifter
module tb_shift_cmd_issuer;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, sh_a, sh_o, out_data;
  logic [3:0] in_amt;
  logic sh_s2, sh_s1, sh_s0;
  logic [2:0] sel;
  logic [2:0] level;
`ifdef SHIFT_OVF_EN
  logic out_ovf;
`endif
  typedef struct {logic [7:0] d; logic ovf;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, n_out = 0;

  shift_cmd_issuer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .sh_a(sh_a), .sh_s2(sh_s2),
    .sh_s1(sh_s1), .sh_s0(sh_s0), .sh_o(sh_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .level(level)
`ifdef SHIFT_OVF_EN
    , .out_ovf(out_ovf)
`endif
  );

  assign sel = {sh_s2, sh_s1, sh_s0};
  assign sh_o = sh_a << sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] d, input logic [3:0] a);
    logic [31:0] w;
    exp_t e;
    w = {24'b0, d} << a;
    e.d = w[7:0];
    e.ovf = |w[31:8];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] a);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_amt = a;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk("push accept", in_ready, 1);
    sb.push_back(model(d, a));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 200) begin
      tick();
      t++;
    end
    chk("drain count", n_out, target);
  endtask

  // Scoreboard: every output handshake must match the oldest expected result
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected out_valid", out_valid, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
`ifdef SHIFT_OVF_EN
        chk("out_ovf", out_ovf, e.ovf);
`endif
        n_out++;
      end
    end

  initial begin
    logic [7:0] b2b [4];
    b2b[0] = 8'h01; b2b[1] = 8'h13; b2b[2] = 8'hFF; b2b[3] = 8'h20;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst level", level, 0);
    chk("rst sh_a", sh_a, 0);
    chk("rst sel", sel, 0);
    chk("rst in_ready", in_ready, 1);
`ifdef SHIFT_OVF_EN
    chk("rst out_ovf", out_ovf, 0);
`endif
    rst_n = 1'b1;
    tick();
    // single pass 0x81<<1 with PASS1 drive and E2 latency
    push(8'h81, 4'd1);
    chk("t1 level", level, 1);
    chk("t1 idle sh_a", sh_a, 0);
    tick();
    chk("t1 pass1 sh_a", sh_a, 8'h81);
    chk("t1 pass1 sel", sel, 1);
    chk("t1 pass1 valid", out_valid, 0);
    tick();
    chk("t1 hold valid", out_valid, 1);
    chk("t1 hold data", out_data, 8'h02);
    // amt 7 single pass, amt 9 two passes
    push(8'h01, 4'd7);
    tick();
    chk("t2 amt7 valid E1", out_valid, 0);
    tick();
    chk("t2 amt7 valid E2", out_valid, 1);
    push(8'h01, 4'd9);
    tick();
    chk("t2 amt9 pass1 sh_a", sh_a, 8'h01);
    chk("t2 amt9 pass1 sel", sel, 7);
    tick();
    chk("t2 amt9 pass2 sh_a", sh_a, 8'h80);
    chk("t2 amt9 pass2 sel", sel, 2);
    chk("t2 amt9 valid E2", out_valid, 0);
    tick();
    chk("t2 amt9 valid E3", out_valid, 1);
    chk("t2 amt9 data", out_data, 8'h00);
    // amt 0 passthrough
    push(8'h5A, 4'd0);
    tick(); tick();
    chk("t3 amt0 valid", out_valid, 1);
    chk("t3 amt0 data", out_data, 8'h5A);
    drain(4);
    // stall: fill FIFO behind a held result
    out_ready = 1'b0;
    push(8'h11, 4'd2);
    push(8'h22, 4'd10);
    push(8'h33, 4'd0);
    push(8'hF0, 4'd4);
    push(8'h0F, 4'd15);
    chk("t4 level full", level, 4);
    chk("t4 in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'hAA; in_amt = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 stall valid", out_valid, 1);
      chk("t4 stall data", out_data, 8'h44);
      chk("t4 stall level", level, 4);
      chk("t4 stall in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(9);
    // reset during PASS2 of an amt-12 command
    push(8'h03, 4'd12);
    tick(); tick();
    chk("t5 pass2 sel", sel, 5);
    chk("t5 pass2 sh_a", sh_a, 8'h80);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t5 rst out_valid", out_valid, 0);
    chk("t5 rst out_data", out_data, 0);
    chk("t5 rst level", level, 0);
    chk("t5 rst sh_a", sh_a, 0);
    chk("t5 rst sel", sel, 0);
    chk("t5 rst in_ready", in_ready, 1);
`ifdef SHIFT_OVF_EN
    chk("t5 rst out_ovf", out_ovf, 0);
`endif
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5 post rst valid", out_valid, 0);
    end
    // back-to-back amt-3 commands, one result every 2nd cycle
    push(b2b[0], 4'd3);
    for (int k = 1; k <= 9; k++) begin
      if (k <= 3) begin
        in_valid = 1'b1; in_data = b2b[k]; in_amt = 4'd3;
        chk("t6 in_ready", in_ready, 1);
        sb.push_back(model(b2b[k], 4'd3));
      end else in_valid = 1'b0;
      tick();
      chk("t6 valid cadence", out_valid, (k % 2 == 0 && k <= 8) ? 1 : 0);
    end
    drain(13);
    chk("sb empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
